// File: rtl/msi_irq_responder.sv
// MSI responder: accepts vector requests, grants after a fixed delay and queues
// the resulting MSI memory-write messages toward the downstream write path.
module msi_irq_responder #(
  parameter int GrantDelay_Gen = 2,
  parameter int FifoDepth_Gen  = 4
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic        MsiEnable_EnIn,
  input  logic [2:0]  MsiMultiMsgEn_DatIn,
  input  logic [31:0] MsiAddr_DatIn,
  input  logic [15:0] MsiData_DatIn,
  input  logic        MsiReq_ValIn,
  input  logic [4:0]  MsiVectorNum_DatIn,
  output logic        MsiGrant_ValOut,
  output logic [2:0]  MsiVectorWidth_DatOut,
  output logic        MsgValid_ValOut,
  input  logic        MsgReady_ValIn,
  output logic [31:0] MsgAddr_DatOut,
  output logic [31:0] MsgData_DatOut,
  output logic [15:0] MsgCount_CntOut,
  output logic        ProtocolErr_FlgOut
);

  localparam int unsigned EffDelay = (GrantDelay_Gen < 1) ? 1 : GrantDelay_Gen;
  localparam int unsigned DlyW     = $clog2(EffDelay) + 1;
  localparam int unsigned PtrW     = $clog2(FifoDepth_Gen);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthVal = CntW'(FifoDepth_Gen);
  localparam logic [DlyW-1:0] DlyLoad  = DlyW'(EffDelay - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StWaitSpace, StGrant} fsmState_t;

  fsmState_t        state, stateNxt;
  logic [DlyW-1:0]  dlyCnt, dlyCntNxt;
  logic             capture, push, pop, errSet;
  logic [31:0]      pendAddr;
  logic [15:0]      pendData;
  logic [PtrW-1:0]  wrPtr, rdPtr;
  logic [CntW-1:0]  fifoCnt;
  logic [31:0]      fifoAddr [FifoDepth_Gen];
  logic [15:0]      fifoData [FifoDepth_Gen];
  logic [15:0]      msgCnt;
  logic             protoErr;
  logic [2:0]       mmeClamp;
  logic [15:0]      vecMask;
  logic [15:0]      reqData;

  // Low m bits of the message data are replaced by the masked vector number
  assign mmeClamp = (MsiMultiMsgEn_DatIn > 3'd5) ? 3'd5 : MsiMultiMsgEn_DatIn;
  assign vecMask  = (16'd1 << mmeClamp) - 16'd1;
  assign reqData  = (MsiData_DatIn & ~vecMask) | ({11'd0, MsiVectorNum_DatIn} & vecMask);

  assign MsiVectorWidth_DatOut = mmeClamp;
  assign MsiGrant_ValOut       = push;
  assign MsgValid_ValOut       = (fifoCnt != '0);
  assign pop                   = MsgValid_ValOut & MsgReady_ValIn;
  assign MsgAddr_DatOut        = MsgValid_ValOut ? fifoAddr[rdPtr] : 32'd0;
  assign MsgData_DatOut        = MsgValid_ValOut ? {16'd0, fifoData[rdPtr]} : 32'd0;
  assign MsgCount_CntOut       = msgCnt;
  assign ProtocolErr_FlgOut    = protoErr;

  // Next-state logic; a disabled link forces Idle and drops the pending request
  always_comb begin
    stateNxt  = state;
    dlyCntNxt = dlyCnt;
    capture   = 1'b0;
    push      = 1'b0;
    errSet    = 1'b0;
    if (MsiEnable_EnIn) begin
      errSet = MsiReq_ValIn && (state != StIdle);
      unique case (state)
        StIdle: begin
          if (MsiReq_ValIn) begin
            capture   = 1'b1;
            dlyCntNxt = DlyLoad;
            stateNxt  = StDelay;
          end
        end
        StDelay: begin
          if (dlyCnt == '0) stateNxt = StWaitSpace;
          else              dlyCntNxt = dlyCnt - DlyW'(1);
        end
        StWaitSpace: begin
          if (fifoCnt < DepthVal) begin
            push     = 1'b1;
            stateNxt = StGrant;
          end
        end
        StGrant:  stateNxt = StIdle;
        default:  stateNxt = StIdle;
      endcase
    end else begin
      stateNxt = StIdle;
    end
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state  <= StIdle;
      dlyCnt <= '0;
    end else begin
      state  <= stateNxt;
      dlyCnt <= dlyCntNxt;
    end
  end

  // Pending message, message FIFO, grant counter and sticky error
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      pendAddr <= '0;
      pendData <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      fifoCnt  <= '0;
      msgCnt   <= '0;
      protoErr <= 1'b0;
      for (int i = 0; i < FifoDepth_Gen; i++) begin
        fifoAddr[i] <= '0;
        fifoData[i] <= '0;
      end
    end else begin
      if (capture) begin
        pendAddr <= MsiAddr_DatIn;
        pendData <= reqData;
      end
      if (errSet) protoErr <= 1'b1;
      if (!MsiEnable_EnIn) begin
        wrPtr   <= '0;
        rdPtr   <= '0;
        fifoCnt <= '0;
      end else begin
        if (push) begin
          fifoAddr[wrPtr] <= pendAddr;
          fifoData[wrPtr] <= pendData;
          wrPtr           <= wrPtr + PtrW'(1);
          msgCnt          <= msgCnt + 16'd1;
        end
        if (pop) rdPtr <= rdPtr + PtrW'(1);
        if (push && !pop)      fifoCnt <= fifoCnt + CntW'(1);
        else if (pop && !push) fifoCnt <= fifoCnt - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_msi_irq_responder.sv
// Bench for msi_irq_responder: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_msi_irq_responder;

  localparam int Depth = 4;
  localparam int Dly   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mme = '0;
  logic [31:0] addr = '0;
  logic [15:0] data = '0;
  logic        req = 1'b0;
  logic [4:0]  vec = '0;
  logic        ready = 1'b0;
  logic        grant;
  logic [2:0]  width;
  logic        mvalid;
  logic [31:0] maddr, mdata;
  logic [15:0] mcount;
  logic        perr;

  int nChecks = 0;
  int nPass   = 0;

  msi_irq_responder #(.GrantDelay_Gen(Dly), .FifoDepth_Gen(Depth)) dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rst_n), .MsiEnable_EnIn(en),
    .MsiMultiMsgEn_DatIn(mme), .MsiAddr_DatIn(addr), .MsiData_DatIn(data),
    .MsiReq_ValIn(req), .MsiVectorNum_DatIn(vec), .MsiGrant_ValOut(grant),
    .MsiVectorWidth_DatOut(width), .MsgValid_ValOut(mvalid), .MsgReady_ValIn(ready),
    .MsgAddr_DatOut(maddr), .MsgData_DatOut(mdata), .MsgCount_CntOut(mcount),
    .ProtocolErr_FlgOut(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else nPass++;
  endtask

  // Model: one transaction in flight with an earliest-grant cycle, plus a queue of messages
  logic [31:0] qAddr[$];
  logic [31:0] qData[$];
  bit          active = 0;
  bit          granted = 0;
  int          eligible = 0;
  int          cyc = 0;
  logic [31:0] pAddr = '0, pData = '0;
  logic [15:0] cntM = '0;
  bit          errM = 0;

  function automatic logic [31:0] msgData(input logic [15:0] d, input logic [4:0] v, input int m);
    int p;
    p = 1 << m;
    return 32'((int'(d) / p) * p + (int'(v) % p));
  endfunction

  always @(negedge clk) begin
    int qsz;
    int m;
    bit gExp;
    if (!rst_n) begin
      qAddr.delete(); qData.delete();
      active = 0; granted = 0; cntM = '0; errM = 0;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_valid", 32'(mvalid), 0);
      chk("rst_addr", maddr, 0);
      chk("rst_data", mdata, 0);
      chk("rst_count", 32'(mcount), 0);
      chk("rst_err", 32'(perr), 0);
    end else begin
      m    = (int'(mme) > 5) ? 5 : int'(mme);
      qsz  = qAddr.size();
      gExp = en && active && !granted && (cyc >= eligible) && (qsz < Depth);
      chk("width", 32'(width), 32'(m));
      chk("grant", 32'(grant), 32'(gExp));
      chk("valid", 32'(mvalid), 32'(qsz != 0));
      if (qsz != 0) begin
        chk("msg_addr", maddr, qAddr[0]);
        chk("msg_data", mdata, qData[0]);
      end
      chk("count", 32'(mcount), 32'(cntM));
      chk("err", 32'(perr), 32'(errM));
      if (!en) begin
        active = 0;
        qAddr.delete(); qData.delete();
      end else begin
        if (req && active) errM = 1;
        if (qsz != 0 && ready) begin
          void'(qAddr.pop_front());
          void'(qData.pop_front());
        end
        if (active && granted) active = 0;
        else if (gExp) begin
          qAddr.push_back(pAddr);
          qData.push_back(pData);
          cntM++;
          granted = 1;
        end else if (!active && req) begin
          active = 1; granted = 0;
          eligible = cyc + Dly + 1;
          pAddr = addr;
          pData = msgData(data, vec, m);
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input logic [4:0] v);
    req = 1'b1;
    vec = v;
    tick();
    req = 1'b0;
  endtask

  task automatic waitGrant(input int maxC, output bit seen);
    seen = 0;
    for (int i = 0; i < maxC; i++) begin
      if (grant) begin
        seen = 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit seen;
    idle(2);
    rst_n = 1'b1;
    en = 1'b1; mme = 3'd5; data = 16'h4A20; addr = 32'hFEE0_1000; ready = 1'b1;
    idle(2);

    // Basic request: grant three cycles after the request cycle
    request(5'd7);
    chk("t1_grant_early1", 32'(grant), 0);
    tick();
    chk("t1_grant_early2", 32'(grant), 0);
    tick();
    chk("t1_grant", 32'(grant), 1);
    tick();
    chk("t1_valid", 32'(mvalid), 1);
    chk("t1_addr", maddr, 32'hFEE0_1000);
    chk("t1_data", mdata, 32'h0000_4A27);
    chk("t1_count", 32'(mcount), 1);
    idle(2);

    // Vector masking with m=2, and MME clamp
    mme = 3'd2;
    #1 chk("t2_width", 32'(width), 2);
    request(5'd13);
    idle(3);
    chk("t2_data", mdata, 32'h0000_4A21);
    mme = 3'd7;
    #1 chk("t2_width_clamp", 32'(width), 5);
    idle(2);

    // Backpressure: four grants fill the FIFO, the fifth waits for a pop
    mme = 3'd5; ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr = 32'hFEE0_2000 + 32'(k * 4);
      request(5'(k + 1));
      waitGrant(10, seen);
      chk("t3_grant_seen", 32'(seen), 1);
      idle(2);
    end
    request(5'd20);
    waitGrant(12, seen);
    chk("t3_fifth_withheld", 32'(seen), 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t3_fifth_grant", 32'(grant), 1);
    tick();
    ready = 1'b1;
    idle(6);
    chk("t3_drained", 32'(mvalid), 0);

    // Protocol error: second request while the first is in Delay
    chk("t4_err_before", 32'(perr), 0);
    request(5'd3);
    request(5'd9);
    waitGrant(10, seen);
    chk("t4_grant_seen", 32'(seen), 1);
    idle(4);
    chk("t4_err_sticky", 32'(perr), 1);

    // Disable with two queued messages and a request in Delay
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      request(5'(k + 10));
      waitGrant(10, seen);
      idle(2);
    end
    request(5'd12);
    en = 1'b0;
    tick();
    chk("t5_valid_off", 32'(mvalid), 0);
    chk("t5_grant_off", 32'(grant), 0);
    request(5'd1);
    tick();
    en = 1'b1; ready = 1'b1;
    idle(1);
    request(5'd17);
    waitGrant(10, seen);
    chk("t5_regrant", 32'(seen), 1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 99) >= 3);
      req   = ($urandom_range(0, 99) < 30);
      vec   = 5'($urandom);
      mme   = 3'($urandom);
      ready = ($urandom_range(0, 99) < 50);
      addr  = $urandom;
      data  = 16'($urandom);
      tick();
    end
    req = 1'b0; en = 1'b1; ready = 1'b1;
    idle(10);

    // Asynchronous reset during a grant cycle
    request(5'd6);
    waitGrant(10, seen);
    chk("t6_grant_seen", 32'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_valid", 32'(mvalid), 0);
    chk("t6_count", 32'(mcount), 0);
    chk("t6_err", 32'(perr), 0);
    chk("t6_addr", maddr, 0);
    chk("t6_data", mdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/msi_irq_responder.md
Name: msi_irq_responder

Overview:
- Responder end of the MSI request/grant interface driven by the interrupt-side MSI requester.
- Accepts single-cycle requests carrying a 5-bit vector number and returns a single-cycle grant.
- Converts each granted request into an MSI memory-write message (address, data) and buffers it in a small FIFO toward the PCIe/AXI write path.
- Used as the bridge-side adapter and as the bench counterpart for the requester.

Parameters:
- GrantDelay_Gen, 2, cycles from request capture to grant pulse; values below 1 behave as 1.
- FifoDepth_Gen, 4, message FIFO depth; must be a power of 2, range 2..16.

Ports:
- SysClk_ClkIn  in  1  system clock
- SysRstN_RstIn  in  1  reset, asynchronous, active-low
- MsiEnable_EnIn  in  1  MSI enable from PCIe config space
- MsiMultiMsgEn_DatIn  in  3  Multiple Message Enable; log2 of allocated vectors
- MsiAddr_DatIn  in  32  MSI message address from config
- MsiData_DatIn  in  16  MSI message data base from config
- MsiReq_ValIn  in  1  request pulse, one cycle
- MsiVectorNum_DatIn  in  5  vector number; valid in the cycle MsiReq_ValIn is high
- MsiGrant_ValOut  out  1  grant pulse, one cycle
- MsiVectorWidth_DatOut  out  3  effective vector width reported to the requester
- MsgValid_ValOut  out  1  message valid
- MsgReady_ValIn  in  1  message accepted by the downstream write path
- MsgAddr_DatOut  out  32  message address
- MsgData_DatOut  out  32  message data
- MsgCount_CntOut  out  16  number of granted messages, wrapping
- ProtocolErr_FlgOut  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - State Idle; FIFO empty.
  - All outputs 0: MsiGrant_ValOut, MsgValid_ValOut, MsgAddr_DatOut, MsgData_DatOut, MsgCount_CntOut, ProtocolErr_FlgOut.
  - MsiVectorWidth_DatOut is combinational from the clamped MME value.
- MME clamp: m = min(MsiMultiMsgEn_DatIn, 5). MsiVectorWidth_DatOut = m.
- Vector masking: vec = MsiVectorNum_DatIn & (2^m - 1).
  - Message data = {16'h0, MsiData_DatIn[15:m], vec[m-1:0]}; with m = 0 the data is {16'h0, MsiData_DatIn}.
  - Message address = MsiAddr_DatIn.
  - Address and data are sampled in the request-capture cycle.
- State machine, advancing only while MsiEnable_EnIn = 1:
  - Idle: on MsiReq_ValIn = 1, capture vec/addr/data into the pending register, load the delay counter with GrantDelay_Gen-1, go to Delay.
  - Delay: decrement the counter; at 0, go to WaitSpace.
  - WaitSpace: if the registered FIFO count < FifoDepth_Gen, push the pending message, assert MsiGrant_ValOut for exactly one cycle, increment MsgCount_CntOut, go to Grant.
  - Grant: deassert the grant, return to Idle.
- Grant latency: with free space and GrantDelay_Gen = d, the grant is high d+1 cycles after the request cycle.
- Full FIFO: the grant is withheld until space exists. The space check uses the count before any same-cycle pop, so full plus a pop gives a grant one cycle later.
- MsiReq_ValIn = 1 in any state other than Idle: request ignored, ProtocolErr_FlgOut set sticky. The flag clears only on reset.
- A request in the Grant cycle is also an error; the requester must wait one cycle.
- FIFO output:
  - MsgValid_ValOut = 1 whenever the FIFO is non-empty; address and data show the head entry.
  - The head is held stable until MsgValid_ValOut & MsgReady_ValIn, which pops the head.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
- Pointers wrap modulo FifoDepth_Gen. MsgCount_CntOut wraps from 0xFFFF to 0.
- MsiEnable_EnIn = 0:
  - Synchronous flush: state Idle, FIFO empty, MsgValid_ValOut low, pending request discarded.
  - No grant is issued and incoming requests are ignored without error.
  - MsgCount_CntOut and ProtocolErr_FlgOut hold.
- Reset mid-operation: immediate return to all reset values, including a grant or message in flight.

Test Plan:
- Request, m=5, defaults:
  - Stimulus: MME=5, Data=0x4A20, Addr=0xFEE0_1000, request vec=7 at cycle T, MsgReady=1.
  - Response: grant at T+3; message {0xFEE0_1000, 0x0000_4A27}; MsgCount=1.
- Masking at m=2:
  - Stimulus: MME=2, Data=0x4A20, vec=13.
  - Response: data 0x0000_4A21; MsiVectorWidth_DatOut=2.
  - Stimulus: MME=7.
  - Response: MsiVectorWidth_DatOut=5.
- Backpressure and full:
  - Stimulus: MsgReady=0, depth 4, five sequential requests, each issued after the previous grant.
  - Response: four grants; the fifth grant is withheld.
  - Stimulus: raise MsgReady for one cycle.
  - Response: one pop; the fifth grant follows in the next cycle; messages exit in order.
- Protocol error:
  - Stimulus: second request one cycle after the first, while in Delay.
  - Response: second request ignored; ProtocolErr_FlgOut=1 and it stays set; only one message is produced.
- Disable mid-operation:
  - Stimulus: two messages queued plus one request in Delay, then MsiEnable=0.
  - Response: next cycle MsgValid=0 and no grant; MsgCount is held. After re-enable, a new request is granted normally.
- Async reset:
  - Stimulus: assert SysRstN_RstIn low during a grant cycle.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
